peripheral_apb4_responder: RTL and testbench

- APB4 completer (slave) terminating the bus driven by the APB4 driver/BFM.
- Holds a small word-addressed register bank and inserts a programmable number of wait states.
- Flags illegal accesses with pslverr.
- Used as the DUT-side responder in the APB4 UVM environment and as a generic peripheral register slice.

---
 rtl/peripheral_apb4_responder.sv | 204 ++++++++++++++++++++
 tb/tb_peripheral_apb4_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_apb4_responder.sv
// peripheral_apb4_responder: APB4 completer with a small word-addressed register
// bank, a programmable number of wait states and error signalling on illegal
// accesses (misaligned, out-of-range index, write to read-only reg 0).
// Register 0 is a read-only ID register; registers 1..NUM_REGS-1 are R/W with
// byte strobes.
// Optional feature macro: PERIPHERAL_APB4_RESPONDER_PSLVERR_EN
//   defined   -> pslverr flags illegal accesses
//   undefined -> pslverr is tied 0; illegal writes are dropped, illegal reads return 0

// One R/W register: byte lanes update independently under their strobe.
module peripheral_apb4_responder_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] strb_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   q_o
);
    localparam int NB = DATA_WIDTH / 8;

    logic [NB-1:0][7:0] q_q;

    // Strobed byte-lane write; unstrobed lanes keep their value.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            q_q <= '0;
        end else if (we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (strb_i[b]) q_q[b] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign q_o = q_q;
endmodule

module peripheral_apb4_responder #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter int                    WAIT_CYCLES = 1,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B4_0001
) (
    input  logic                             pclk,
    input  logic                             presetn,
    input  logic [ADDR_WIDTH-1:0]            paddr,
    input  logic                             psel,
    input  logic                             penable,
    input  logic                             pwrite,
    input  logic [DATA_WIDTH/8-1:0]          pstrb,
    input  logic [DATA_WIDTH-1:0]            pwdata,
    output logic [DATA_WIDTH-1:0]            prdata,
    output logic                             pready,
    output logic                             pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0]   regs_o
);
    localparam int         SW      = DATA_WIDTH / 8;
    localparam int         IW      = ADDR_WIDTH - 2;
    localparam int         RW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic [SW-1:0]         strb;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    req_t                  req_q, req_d, req_in, resp_req;
    logic                  pready_q, pready_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  go_resp, resp_err, wr_commit;
    logic [DATA_WIDTH-1:0] regs_w [NUM_REGS];

    // An access is illegal if misaligned, past the bank, or a write to the ID reg.
    function automatic logic illegal(input req_t r);
        logic [IW-1:0] idx;
        idx = r.addr[ADDR_WIDTH-1:2];
        return (r.addr[1:0] != 2'b00) || (idx >= IW'(NUM_REGS)) ||
               (r.write && (idx == '0));
    endfunction

    assign req_in.addr  = paddr;
    assign req_in.write = pwrite;
    assign req_in.strb  = pstrb;
    assign req_in.wdata = pwdata;

    // Next-state and registered-output logic. Outputs are computed one edge
    // early so pready/prdata/pslverr come straight from flops in RESP.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        pready_d = 1'b0;
        prdata_d = '0;
        go_resp  = 1'b0;
        resp_req = req_q;
        resp_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Only a proper setup phase starts a transfer; a stray
                // penable without setup is ignored.
                if (psel && !penable) begin
                    req_d = req_in;
                    cnt_d = WAIT_LD;
                    if (WAIT_CYCLES == 0) begin
                        go_resp  = 1'b1;
                        resp_req = req_in;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!psel) begin
                    // Bus master abandoned the transfer: nothing commits.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (penable) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) go_resp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (go_resp) begin
            state_d  = RESP;
            pready_d = 1'b1;
            resp_err = illegal(resp_req);
            if (!resp_req.write && !resp_err)
                prdata_d = regs_w[resp_req.addr[2 +: RW]];
        end
    end

    // State, counter, latched request and response registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            req_q    <= '0;
            pready_q <= 1'b0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            pready_q <= pready_d;
            prdata_q <= prdata_d;
        end
    end

`ifdef PERIPHERAL_APB4_RESPONDER_PSLVERR_EN
    logic pslverr_q;

    // Error flag is valid only alongside pready.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) pslverr_q <= 1'b0;
        else          pslverr_q <= go_resp && resp_err;
    end

    assign pslverr = pslverr_q;
`else
    assign pslverr = 1'b0;
`endif

    assign pready = pready_q;
    assign prdata = prdata_q;

    // Writes commit on the edge that completes the RESP cycle, so regs_o shows
    // the new value in the cycle after pready.
    assign wr_commit = (state_q == RESP) && req_q.write && !illegal(req_q);

    assign regs_w[0] = ID_VALUE;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        logic we;
        assign we = wr_commit && (req_q.addr[2 +: RW] == RW'(i));
        peripheral_apb4_responder_reg #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_reg (
            .pclk    (pclk),
            .presetn (presetn),
            .we_i    (we),
            .strb_i  (req_q.strb),
            .wdata_i (req_q.wdata),
            .q_o     (regs_w[i])
        );
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_w[i];
    end
endmodule

// File: tb/tb_peripheral_apb4_responder.sv
// Testbench for peripheral_apb4_responder: three instances with 1, 0 and 3
// wait states share a clock/reset; a scoreboard queue of expected responses is
// filled by the driver and drained by an independent monitor on pready.
module tb_peripheral_apb4_responder;
    localparam int          NDUT = 3;
    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam int          SW   = 4;
    localparam int          NR   = 8;
    localparam logic [31:0] ID   = 32'hA9B4_0001;
`ifdef PERIPHERAL_APB4_RESPONDER_PSLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic pclk = 1'b0;
    logic presetn = 1'b0;

    logic [AW-1:0]    paddr   [NDUT];
    logic             psel    [NDUT];
    logic             penable [NDUT];
    logic             pwrite  [NDUT];
    logic [SW-1:0]    pstrb   [NDUT];
    logic [DW-1:0]    pwdata  [NDUT];
    logic [DW-1:0]    prdata  [NDUT];
    logic             pready  [NDUT];
    logic             pslverr [NDUT];
    logic [NR*DW-1:0] regs_o  [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        peripheral_apb4_responder #(
            .WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 0 : 3)
        ) u_dut (
            .pclk    (pclk),
            .presetn (presetn),
            .paddr   (paddr[g]),
            .psel    (psel[g]),
            .penable (penable[g]),
            .pwrite  (pwrite[g]),
            .pstrb   (pstrb[g]),
            .pwdata  (pwdata[g]),
            .prdata  (prdata[g]),
            .pready  (pready[g]),
            .pslverr (pslverr[g]),
            .regs_o  (regs_o[g])
        );
    end

    always #5 pclk = ~pclk;

    typedef struct {
        int          k;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mem [NDUT][NR];
    int          n_chk  = 0;
    int          n_pass = 0;

    function automatic int wc_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 0 : 3;
    endfunction

    task automatic check(input string name, input int k,
                         input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h, expected %0h", name, k, act, exp);
    endtask

    function automatic logic [NR*DW-1:0] model_flat(input int k);
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = (i == 0) ? ID : mem[k][i];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++)
            for (int i = 0; i < NR; i++) mem[k][i] = '0;
    endtask

    // Full APB transfer; expectation is queued at setup time. Returns with psel
    // low at #1 after the completing edge, so a following call is back-to-back.
    task automatic xfer(input int k, input logic [31:0] a, input logic w,
                        input logic [3:0] s, input logic [31:0] d);
        exp_t        e;
        bit          bad;
        int unsigned idx;
        int          waits;
        idx   = a >> 2;
        bad   = (a[1:0] != 2'b00) || (idx >= NR) || (w && idx == 0);
        e.k   = k;
        e.err = ERR_EN && bad;
        e.data = '0;
        if (!w && !bad) e.data = (idx == 0) ? ID : mem[k][idx];
        sbq.push_back(e);
        if (w && !bad)
            for (int b = 0; b < SW; b++)
                if (s[b]) mem[k][idx][8*b +: 8] = d[8*b +: 8];
        paddr[k] = a; pwrite[k] = w; pstrb[k] = s; pwdata[k] = d;
        psel[k] = 1'b1; penable[k] = 1'b0;
        @(posedge pclk); #1;
        penable[k] = 1'b1;
        waits = 0;
        @(negedge pclk);
        while (!pready[k] && waits <= 40) begin
            waits++;
            @(negedge pclk);
        end
        check("wait_states", k, waits, wc_of(k));
        @(posedge pclk); #1;
        psel[k] = 1'b0; penable[k] = 1'b0;
        check("post_resp_pready", k, pready[k], 0);
        check("post_resp_prdata", k, prdata[k], 0);
        check("regs_o", k, regs_o[k], model_flat(k));
    endtask

    // Write started and abandoned by dropping psel while the slave waits.
    task automatic abort_write(input int k, input logic [31:0] a, input logic [31:0] d);
        paddr[k] = a; pwrite[k] = 1'b1; pstrb[k] = 4'hF; pwdata[k] = d;
        psel[k] = 1'b1; penable[k] = 1'b0;
        @(posedge pclk); #1;
        if (wc_of(k) >= 2) begin
            penable[k] = 1'b1;
            @(posedge pclk); #1;
        end
        psel[k] = 1'b0; penable[k] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            check("abort_no_pready", k, pready[k], 0);
        end
        @(posedge pclk); #1;
        check("abort_regs_o", k, regs_o[k], model_flat(k));
    endtask

    // Monitor: every pready pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge pclk);
            for (int k = 0; k < NDUT; k++) begin
                if (pready[k]) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_pready", k, 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        check("resp_dut", k, k, e.k);
                        check("prdata", k, prdata[k], e.data);
                        check("pslverr", k, pslverr[k], e.err);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        for (int k = 0; k < NDUT; k++) begin
            paddr[k] = '0; psel[k] = 1'b0; penable[k] = 1'b0;
            pwrite[k] = 1'b0; pstrb[k] = '0; pwdata[k] = '0;
        end
        model_reset();
        presetn = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check("reset_pready", k, pready[k], 0);
            check("reset_prdata", k, prdata[k], 0);
            check("reset_pslverr", k, pslverr[k], 0);
            check("reset_regs_o", k, regs_o[k], model_flat(k));
        end
        @(negedge pclk);
        presetn = 1'b1;
        @(posedge pclk); #1;

        for (int k = 0; k < NDUT; k++) begin
            xfer(k, 32'h0, 1'b0, 4'h0, 32'h0);
            xfer(k, 32'h4, 1'b1, 4'hF, 32'hDEAD_BEEF);
            xfer(k, 32'h4, 1'b1, 4'h2, 32'h0000_1200);
            xfer(k, 32'h4, 1'b0, 4'h0, 32'h0);
            check("reg1_bytes", k, regs_o[k][63:32], 32'hDEAD_12EF);
            xfer(k, 32'h0, 1'b1, 4'hF, 32'hFFFF_FFFF);
            xfer(k, 32'h22, 1'b0, 4'h0, 32'h0);
            xfer(k, 32'h20, 1'b0, 4'h0, 32'h0);
            check("reg0_id", k, regs_o[k][31:0], ID);
            xfer(k, 32'h8, 1'b1, 4'hF, $urandom);
            xfer(k, 32'h8, 1'b0, 4'h0, 32'h0);
            if (wc_of(k) > 0) begin
                abort_write(k, 32'hC, 32'h1234_5678);
                xfer(k, 32'hC, 1'b0, 4'h0, 32'h0);
            end
            for (int n = 0; n < 40; n++) begin
                a = 32'($urandom_range(0, 9)) * 4;
                if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
                xfer(k, a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge pclk); #1;
                end
            end
        end

        // Reset in the middle of a write's wait state on the 1-wait instance.
        xfer(0, 32'h10, 1'b1, 4'hF, 32'hCAFE_F00D);
        paddr[0] = 32'h10; pwrite[0] = 1'b1; pstrb[0] = 4'hF; pwdata[0] = 32'h55AA_55AA;
        psel[0] = 1'b1; penable[0] = 1'b0;
        @(posedge pclk); #1;
        penable[0] = 1'b1;
        #2;
        presetn = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check("midreset_pready", k, pready[k], 0);
            check("midreset_prdata", k, prdata[k], 0);
            check("midreset_pslverr", k, pslverr[k], 0);
            check("midreset_regs_o", k, regs_o[k], model_flat(k));
        end
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        @(posedge pclk); #1;
        check("midreset_reg4", 0, regs_o[0][159:128], 0);
        xfer(0, 32'h10, 1'b0, 4'h0, 32'h0);

        repeat (3) @(posedge pclk);
        #1;
        check("scoreboard_drained", 0, sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
